alu_issue_decode: RTL
=====================

// Module: alu_issue_decode
// PURPOSE
//  Decoder/issue stage producing alu_op, alu_src1 and alu_src2 for the ALU from RV32I ALU-class instructions.
//  Covers OP, OP-IMM, LUI and AUIPC; selects operands and rd/write-enable.
//  Registered stage with valid/ready handshakes on both sides; sits between fetch/regfile read and execute.
// PARAMETERS
//  XLEN     32   datapath width; only 32 is supported
//  OPW      4    alu_op width; must match the ALU encoding
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     upstream entry valid
//  in_ready     out  1     stage can accept an entry this cycle
//  in_instr     in   32    instruction word
//  in_pc        in   32    PC of in_instr
//  rs1_data     in   32    regfile value of instr[19:15]
//  rs2_data     in   32    regfile value of instr[24:20]
//  out_valid    out  1     decoded entry valid
//  out_ready    in   1     execute consumes the entry
//  out_alu_op   out  4     ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 NOP=15
//  out_src1     out  32    ALU operand 1
//  out_src2     out  32    ALU operand 2
//  out_rd       out  5     destination register, instr[11:7]
//  out_wen      out  1     register write enable
//  out_illegal  out  1     entry is not a legal ALU-class instruction
// BEHAVIOUR
//  - Reset: out_valid=0, out_alu_op=15, out_src1/src2=0, out_rd=0, out_wen=0, out_illegal=0.
//    in_ready=0 while rst=1. Reset mid-transfer drops any held entry.
//  - Transfer rules: input fires on in_valid&&in_ready; output fires on out_valid&&out_ready.
//    Latency is one cycle from input fire to out_valid=1.
//  - While out_valid&&!out_ready, all out_* signals are held stable. No entry is lost or duplicated.
//  - Simultaneous output fire and input fire in the same cycle: the new entry replaces the old one, out_valid stays 1.
//  - OP (0110011), funct7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
//    OP, funct7=0100000: f3 000 SUB, 101 SRA. Any other funct7/f3 combination is illegal.
//    Operands: src1=rs1_data, src2=rs2_data.
//  - OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI use src2 = sign-extended instr[31:20].
//    SLTIU compares that sign-extended value unsigned.
//    SLLI/SRLI need funct7=0000000; SRAI needs 0100000; any other funct7 is illegal.
//  - Shift amount: every shift (register or immediate) drives src2={27'b0,shamt[4:0]}.
//    The ALU consumes the full 32-bit src2, so this masking is mandatory.
//  - LUI (0110111): ADD, src1=0, src2={instr[31:12],12'b0}.
//  - AUIPC (0010111): ADD, src1=in_pc, src2={instr[31:12],12'b0}.
//  - Illegal (any other opcode, or a bad funct field): alu_op=15, src1=src2=0, wen=0, illegal=1.
//    The entry still flows through the handshake.
//  - out_wen = legal && (rd != 0).
// CONFIGURATION
//  ALU_ISSUE_SKID_EN
//  - Undefined: single output register.
//    in_ready = !rst && (!out_valid || out_ready), i.e. combinational from out_ready.
//  - Defined: adds a one-entry skid buffer behind the output register.
//    in_ready is a registered signal, = !skid_valid.
//    An entry accepted while the output stalls is parked in the skid buffer.
//    The skid entry moves to the output on the next output fire.
//    Order is preserved; latency is still one cycle when there is no stall; reset clears both entries.
// TESTING
//  1. ADD x3,x1,x2: 0x002081B3, rs1=5, rs2=7
//     -> next cycle: op=0, src1=5, src2=7, rd=3, wen=1, illegal=0.
//  2. SRAI x5,x1,4: 0x4040D293, rs1=0x80000000
//     -> op=7, src1=0x80000000, src2=0x00000004, rd=5.
//  3. SLL x3,x1,x2: 0x002091B3, rs2=0x00000025
//     -> op=2, src2=0x00000005.
//  4. LUI x1,0x12345: 0x123450B7
//     -> op=0, src1=0, src2=0x12345000.
//     ADDI x0,x0,-1: 0xFFF00013
//     -> op=0, src2=0xFFFFFFFF, wen=0.
//  5. Backpressure: hold out_ready=0 for 3 cycles while 4 back-to-back entries are offered
//     -> first entry held stable; in_ready follows the mode rules; after release, 4 outputs in order, none dropped.
//  6. Illegal opcode 0x0000007F -> op=15, wen=0, illegal=1.
//     Then assert rst with out_valid=1 -> out_valid=0 on the next edge.

Source files
------------

// File: rtl/alu_issue_decode.sv
// RV32I ALU-class decode/issue stage: OP, OP-IMM, LUI, AUIPC to alu_op/src1/src2.
// Define ALU_ISSUE_SKID_EN for a registered in_ready backed by a one-entry skid buffer.
module alu_issue_decode #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  out_alu_op,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic            out_illegal
);

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] s1;
        logic [XLEN-1:0] s2;
        logic [4:0]      rd;
        logic            wen;
        logic            ill;
    } ent_t;

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_SLL = OPW'(2);
    localparam logic [OPW-1:0] OP_SRA = OPW'(7);
    localparam logic [OPW-1:0] OP_SRL = OPW'(6);
    localparam logic [OPW-1:0] OP_NOP = OPW'(15);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam ent_t RST_ENT = '{
        op: OP_NOP, s1: '0, s2: '0, rd: '0, wen: 1'b0, ill: 1'b0
    };

    // funct3 to ALU op for the funct7=0 / immediate group
    function automatic logic [OPW-1:0] f3_op(input logic [2:0] f3);
        logic [OPW-1:0] op;
        case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OPW'(3);
            3'b011:  op = OPW'(4);
            3'b100:  op = OPW'(5);
            3'b101:  op = OP_SRL;
            3'b110:  op = OPW'(8);
            default: op = OPW'(9);
        endcase
        return op;
    endfunction

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_sh_reg;
    logic [XLEN-1:0] w_sh_imm;
    logic            w_legal;
    logic [OPW-1:0]  w_op;
    logic [XLEN-1:0] w_s1;
    logic [XLEN-1:0] w_s2;
    ent_t            w_dec;
    logic            w_unused;

    assign w_opc    = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_rd     = in_instr[11:7];
    assign w_imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign w_imm_u  = {in_instr[31:12], 12'b0};
    assign w_sh_reg = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
    assign w_sh_imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};
    assign w_unused = ^in_instr[19:15];

    always_comb begin
        w_legal = 1'b0;
        w_op    = OP_NOP;
        w_s1    = '0;
        w_s2    = '0;
        case (w_opc)
            OPC_OP: begin
                w_s1 = rs1_data;
                w_s2 = rs2_data;
                if (w_f7 == F7_BASE) begin
                    w_legal = 1'b1;
                    w_op    = f3_op(w_f3);
                    if (w_f3 == 3'b001 || w_f3 == 3'b101)
                        w_s2 = w_sh_reg;
                end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
                    w_legal = 1'b1;
                    w_op    = OP_SUB;
                end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
                    w_legal = 1'b1;
                    w_op    = OP_SRA;
                    w_s2    = w_sh_reg;
                end
            end
            OPC_OPIMM: begin
                w_s1 = rs1_data;
                case (w_f3)
                    3'b001: begin
                        w_legal = (w_f7 == F7_BASE);
                        w_op    = OP_SLL;
                        w_s2    = w_sh_imm;
                    end
                    3'b101: begin
                        w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                        w_op    = (w_f7 == F7_ALT) ? OP_SRA : OP_SRL;
                        w_s2    = w_sh_imm;
                    end
                    default: begin
                        w_legal = 1'b1;
                        w_op    = f3_op(w_f3);
                        w_s2    = w_imm_i;
                    end
                endcase
            end
            OPC_LUI: begin
                w_legal = 1'b1;
                w_op    = OP_ADD;
                w_s2    = w_imm_u;
            end
            OPC_AUIPC: begin
                w_legal = 1'b1;
                w_op    = OP_ADD;
                w_s1    = in_pc;
                w_s2    = w_imm_u;
            end
            default: w_legal = 1'b0;
        endcase
        if (w_legal)
            w_dec = '{op: w_op, s1: w_s1, s2: w_s2, rd: w_rd,
                      wen: (w_rd != 5'd0), ill: 1'b0};
        else
            w_dec = '{op: OP_NOP, s1: '0, s2: '0, rd: w_rd,
                      wen: 1'b0, ill: 1'b1};
    end

    ent_t r_out;
    logic r_valid;
    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_valid && out_ready;

`ifdef ALU_ISSUE_SKID_EN
    ent_t r_skid;
    logic r_skid_valid;
    logic r_ready;
    logic w_skid_nxt;

    // Skid holds an entry only while a second one is parked behind a stall
    assign w_skid_nxt = r_skid_valid ? !w_out_fire
                                     : (w_in_fire && r_valid && !out_ready);
    assign in_ready   = r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= RST_ENT;
            r_valid      <= 1'b0;
            r_skid       <= RST_ENT;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            if (r_skid_valid) begin
                if (w_out_fire)
                    r_out <= r_skid;
            end else if (w_in_fire) begin
                if (!r_valid || out_ready) begin
                    r_out   <= w_dec;
                    r_valid <= 1'b1;
                end else begin
                    r_skid <= w_dec;
                end
            end else if (w_out_fire) begin
                r_valid <= 1'b0;
            end
            r_skid_valid <= w_skid_nxt;
            r_ready      <= !w_skid_nxt;
        end
    end
`else
    assign in_ready = !rst && (!r_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= RST_ENT;
            r_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_out   <= w_dec;
            r_valid <= 1'b1;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end
`endif

    assign out_valid   = r_valid;
    assign out_alu_op  = r_out.op;
    assign out_src1    = r_out.s1;
    assign out_src2    = r_out.s2;
    assign out_rd      = r_out.rd;
    assign out_wen     = r_out.wen;
    assign out_illegal = r_out.ill;

endmodule
